fp_div: RTL and testbench
=========================

Name: fp_div

Overview:
- Sequential IEEE-style floating-point divider for fp_t operands; computes op_a_i / op_b_i.
- Inverse operation of the team's combinational fp multiplier, with the same number semantics:
  - no denormals;
  - truncating, no rounding;
  - underflow flushes to FPZero;
  - overflow saturates to signed infinity;
  - any NaN input gives FPStdNaN.
- Uses an iterative restoring mantissa divider behind a valid/ready handshake on both sides.
- Sits beside fp_mul in the tiny-nn datapath for normalisation/activation steps.

Parameters:
- DivBitsPerCycle, 1, quotient bits produced per DIVIDE cycle. Legal values are 1 or 2. Iterations = ceil((FPMantWidth+1)/DivBitsPerCycle).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous, active-high reset
- valid_i  input  1  operands valid
- ready_o  output  1  block can accept operands (high only in IDLE)
- op_a_i  input  fp_t  dividend
- op_b_i  input  fp_t  divisor
- valid_o  output  1  result valid; held until consumed
- ready_i  input  1  downstream accepts result
- result_o  output  fp_t  quotient; stable while valid_o=1

Behaviour:
- Reset: one clock, clk_i; rst_i is asynchronous and active-high. Asserting rst_i at any time, including mid-divide, forces:
  - state IDLE;
  - ready_o=1, valid_o=0, result_o=FPZero;
  - iteration counter 0.
  No partial result survives reset.
- States: IDLE, DIVIDE, DONE.
- IDLE:
  - ready_o=1. On valid_i=1, operands are captured and the case is classified.
  - Special cases go to DONE next cycle with the result latched.
  - All other cases go to DIVIDE.
- Special-case priority:
  1. Either input NaN → FPStdNaN.
  2. inf/inf or 0/0 → FPStdNaN.
  3. a=inf or b=0 → signed inf (sgn = a.sgn^b.sgn).
  4. a=0 or b=inf → FPZero.
- Normal setup on capture:
  - ma={1,a.mant}, mb={1,b.mant}.
  - If ma<mb, the remainder starts as ma<<1 and adj=1; otherwise it starts as ma and adj=0.
  - Signed exponent, FPExpWidth+2 bits: e = a.exp - b.exp + Bias - adj, where Bias = 2^(FPExpWidth-1)-1.
- DIVIDE:
  - Each step: if rem>=mb, then q_bit=1 and rem=(rem-mb)<<1; else q_bit=0 and rem=rem<<1.
  - Quotient shifts left by one per bit.
  - After the final iteration go to DONE. The quotient MSB is always 1 and is dropped; result mant = quotient[FPMantWidth-1:0]. Remainder is discarded (truncation).
- Result selection on DIVIDE exit:
  - e<=0 → FPZero (unsigned zero, same as the multiplier).
  - e>=all-ones exp → signed inf.
  - Otherwise {sgn, e[FPExpWidth-1:0], mant}.
- DONE:
  - valid_o=1 and result_o is held stable.
  - valid_o&&ready_i → IDLE on the next cycle. ready_o returns at that point, so there is never overlap between a held result and a new capture.
- Latency, with operands accepted at edge N:
  - special case: valid_o high after edge N+1;
  - normal case: valid_o high after edge N+1+Iterations.
  - Throughput is one operation per (latency+1) cycles when ready_i is held high.
- valid_i while busy is ignored (ready_o=0); operands are not re-sampled.
- The captured operands are used, so op_a_i/op_b_i may change after acceptance.

Decomposition:
- Shared package tiny_nn_pkg, reused as-is: fp_t, FPExpWidth, FPMantWidth, FPZero, FPStdNaN, FPPosInf, FPNegInf, is_nan.
- Add to the package:
  - is_inf(fp_t) function;
  - FPExpBias localparam;
  - fp_div_state_e enum {IDLE, DIVIDE, DONE}.
- One combinational sub-module fp_div_step: inputs rem and mb; outputs next rem and DivBitsPerCycle quotient bits. It is instantiated once in fp_div.

Test Plan (examples at FPExpWidth=8, FPMantWidth=7, Bias 127, DivBitsPerCycle=1):
- 6.0/2.0 (0x40C0/0x4000), ready_i=1 → valid_o after 9 cycles; result 0x4040 (3.0). ready_o low throughout, then high the cycle after consume.
- 1.0/3.0 (0x3F80/0x4040) → 0x3EAA (truncated 0.333). Exercises adj=1, exponent 125.
- -1.0/0 → 0xFF80 (-inf) after 1 cycle. 0/0 → FPStdNaN. NaN/2.0 → FPStdNaN. 0/5.0 → FPZero. 4.0/inf → FPZero.
- Range limits:
  - min-normal/large (0x0080/0x7F00) → FPZero (underflow).
  - large/min-normal (0x7F00/0x0080) → 0x7F80 (+inf, overflow).
- Backpressure: hold ready_i=0 for 5 cycles after valid_o. result_o and valid_o must stay stable, and valid_i pulses during that time must not be captured.
- Assert rst_i asynchronously mid-DIVIDE (between edges) → valid_o=0, ready_o=1, result_o=FPZero immediately. A subsequent 6.0/2.0 gives the correct 3.0.

Source files
------------

// File: rtl/tiny_nn_pkg.sv
// Shared number format and helpers for the tiny-nn datapath (fp_mul, fp_div).
// No denormals: a zero exponent field always means zero.
package tiny_nn_pkg;

  localparam int FPExpWidth  = 8;
  localparam int FPMantWidth = 7;
  localparam int FPExpBias   = 2 ** (FPExpWidth - 1) - 1;

  typedef struct packed {
    logic                   sgn;
    logic [FPExpWidth-1:0]  exp;
    logic [FPMantWidth-1:0] mant;
  } fp_t;

  localparam fp_t FPZero   = '{sgn: 1'b0, exp: '0, mant: '0};
  localparam fp_t FPPosInf = '{sgn: 1'b0, exp: '1, mant: '0};
  localparam fp_t FPNegInf = '{sgn: 1'b1, exp: '1, mant: '0};
  localparam fp_t FPStdNaN = '{sgn: 1'b0, exp: '1, mant: {1'b1, {(FPMantWidth-1){1'b0}}}};

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } fp_div_state_e;

  function automatic logic is_nan(fp_t x);
    return (&x.exp) && (|x.mant);
  endfunction

  function automatic logic is_inf(fp_t x);
    return (&x.exp) && !(|x.mant);
  endfunction

  function automatic logic is_zero(fp_t x);
    return x.exp == '0;
  endfunction

endpackage

// File: rtl/fp_div_step.sv
// One combinational slice of the restoring mantissa divider: Bits quotient bits per call.
module fp_div_step #(
  parameter int MantW = 8,
  parameter int Bits  = 1
) (
  input  logic [MantW:0]   i_rem,
  input  logic [MantW-1:0] i_mb,
  output logic [MantW:0]   o_rem,
  output logic [Bits-1:0]  o_q
);

  logic [MantW:0] w_rem;

  // rem < 2*mb holds throughout, so the shifted remainder always fits MantW+1 bits
  always_comb begin
    w_rem = i_rem;
    o_q   = '0;
    for (int i = 0; i < Bits; i++) begin
      if (w_rem >= {1'b0, i_mb}) begin
        o_q[Bits-1-i] = 1'b1;
        w_rem = (w_rem - {1'b0, i_mb}) << 1;
      end else begin
        w_rem = w_rem << 1;
      end
    end
    o_rem = w_rem;
  end

endmodule

// File: rtl/fp_div.sv
// Sequential fp_t divider (a/b): truncating, no denormals, restoring mantissa core.
//   state  | meaning
//   IDLE   | ready_o=1, capture operands, classify special cases
//   DIVIDE | produce DivBitsPerCycle quotient bits per cycle
//   DONE   | valid_o=1, result held until ready_i
module fp_div
  import tiny_nn_pkg::*;
#(
  parameter int DivBitsPerCycle = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic ready_o,
  input  fp_t  op_a_i,
  input  fp_t  op_b_i,
  output logic valid_o,
  input  logic ready_i,
  output fp_t  result_o
);

  localparam int MantW      = FPMantWidth + 1;
  localparam int Iterations = (MantW + DivBitsPerCycle - 1) / DivBitsPerCycle;
  localparam int QuotW      = Iterations * DivBitsPerCycle;
  localparam int CntW       = $clog2(Iterations);
  localparam int ExpW       = FPExpWidth + 2;
  localparam logic signed [ExpW-1:0] ExpMax = ExpW'((1 << FPExpWidth) - 1);

  fp_div_state_e r_state, w_state_nxt;

  logic [MantW:0]                 r_rem, w_rem_nxt;
  logic [MantW-1:0]               r_mb;
  logic [QuotW-1:0]               r_q, w_q_nxt;
  logic [DivBitsPerCycle-1:0]     w_q_bits;
  logic signed [ExpW-1:0]         r_exp, w_exp_init;
  logic                           r_sgn;
  logic [CntW-1:0]                r_cnt;
  fp_t                            r_result;

  logic [MantW-1:0]   w_ma, w_mb;
  logic               w_lt, w_sgn, w_special, w_last;
  fp_t                w_spec_res, w_norm_res;
  logic [FPMantWidth-1:0] w_mant;
  logic               w_unused_q;

  assign w_sgn = op_a_i.sgn ^ op_b_i.sgn;
  assign w_ma  = {1'b1, op_a_i.mant};
  assign w_mb  = {1'b1, op_b_i.mant};
  assign w_lt  = w_ma < w_mb;
  assign w_exp_init = {2'b00, op_a_i.exp} - {2'b00, op_b_i.exp}
                    + ExpW'(FPExpBias) - ExpW'(w_lt);

  always_comb begin
    w_special  = 1'b1;
    w_spec_res = FPStdNaN;
    if (is_nan(op_a_i) || is_nan(op_b_i)) begin
      w_spec_res = FPStdNaN;
    end else if ((is_inf(op_a_i) && is_inf(op_b_i)) ||
                 (is_zero(op_a_i) && is_zero(op_b_i))) begin
      w_spec_res = FPStdNaN;
    end else if (is_inf(op_a_i) || is_zero(op_b_i)) begin
      w_spec_res = w_sgn ? FPNegInf : FPPosInf;
    end else if (is_zero(op_a_i) || is_inf(op_b_i)) begin
      w_spec_res = FPZero;
    end else begin
      w_special = 1'b0;
    end
  end

  fp_div_step #(
    .MantW (MantW),
    .Bits  (DivBitsPerCycle)
  ) u_step (
    .i_rem (r_rem),
    .i_mb  (r_mb),
    .o_rem (w_rem_nxt),
    .o_q   (w_q_bits)
  );

  assign w_q_nxt    = {r_q[QuotW-DivBitsPerCycle-1:0], w_q_bits};
  assign w_last     = r_cnt == CntW'(Iterations - 1);
  // quotient MSB is the hidden one; any bits beyond the mantissa are truncated
  assign w_mant     = w_q_nxt[QuotW-2 -: FPMantWidth];
  assign w_unused_q = ^r_q[QuotW-1 -: DivBitsPerCycle];

  always_comb begin
    if (r_exp <= 0) begin
      w_norm_res = FPZero;
    end else if (r_exp >= ExpMax) begin
      w_norm_res = r_sgn ? FPNegInf : FPPosInf;
    end else begin
      w_norm_res = '{sgn: r_sgn, exp: r_exp[FPExpWidth-1:0], mant: w_mant};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (valid_i) w_state_nxt = w_special ? DONE : DIVIDE;
      DIVIDE:  if (w_last)  w_state_nxt = DONE;
      DONE:    if (ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (r_state == IDLE);
    valid_o = (r_state == DONE);
  end

  assign result_o = r_result;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rem    <= '0;
      r_mb     <= '0;
      r_q      <= '0;
      r_exp    <= '0;
      r_sgn    <= 1'b0;
      r_cnt    <= '0;
      r_result <= FPZero;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_sgn <= w_sgn;
            r_mb  <= w_mb;
            r_rem <= w_lt ? {w_ma, 1'b0} : {1'b0, w_ma};
            r_exp <= w_exp_init;
            r_q   <= '0;
            r_cnt <= '0;
            if (w_special) r_result <= w_spec_res;
          end
        end
        DIVIDE: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + CntW'(1);
          if (w_last) r_result <= w_norm_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// Scoreboard bench for fp_div: directed corner cases, backpressure, async reset, random ops.
module tb_fp_div;
  import tiny_nn_pkg::*;

  localparam int ITER    = (FPMantWidth + 1 + 1 - 1) / 1;
  localparam int LAT_SPC = 1;
  localparam int LAT_NRM = 1 + ITER;

  logic clk_i, rst_i, valid_i, ready_o, valid_o, ready_i;
  fp_t  op_a_i, op_b_i, result_o;

  fp_div #(.DivBitsPerCycle(1)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o)
  );

  typedef struct {
    fp_t res;
    int  lat;
    int  drive_cyc;
  } exp_t;

  exp_t scb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   rdy_rand = 0;
  bit   prev_v = 0;
  bit   exp_rdy = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: a/b = (ma/mb) * 2^(ea-eb), mantissa quotient truncated to FPMantWidth bits.
  function automatic fp_t ref_div(input fp_t a, input fp_t b);
    fp_t r;
    int ea, eb, ma, mb, e, q;
    bit sgn;
    bit a_nan, b_nan, a_inf, b_inf, a_z, b_z;
    sgn   = a.sgn ^ b.sgn;
    ea    = int'(a.exp);
    eb    = int'(b.exp);
    a_nan = (ea == 255) && (a.mant != 0);
    b_nan = (eb == 255) && (b.mant != 0);
    a_inf = (ea == 255) && (a.mant == 0);
    b_inf = (eb == 255) && (b.mant == 0);
    a_z   = (ea == 0);
    b_z   = (eb == 0);
    if (a_nan || b_nan) return FPStdNaN;
    if ((a_inf && b_inf) || (a_z && b_z)) return FPStdNaN;
    if (a_inf || b_z) return sgn ? FPNegInf : FPPosInf;
    if (a_z || b_inf) return FPZero;
    ma = (1 << FPMantWidth) + int'(a.mant);
    mb = (1 << FPMantWidth) + int'(b.mant);
    e  = ea - eb + FPExpBias;
    if (ma >= mb) begin
      q = (ma << FPMantWidth) / mb;
    end else begin
      q = (ma << (FPMantWidth + 1)) / mb;
      e = e - 1;
    end
    if (e <= 0) return FPZero;
    if (e >= 255) return sgn ? FPNegInf : FPPosInf;
    r.sgn  = sgn;
    r.exp  = e[FPExpWidth-1:0];
    r.mant = q[FPMantWidth-1:0];
    return r;
  endfunction

  function automatic bit is_special(input fp_t a, input fp_t b);
    return (a.exp == 0) || (a.exp == 8'hFF) || (b.exp == 0) || (b.exp == 8'hFF);
  endfunction

  function automatic fp_t rand_fp();
    fp_t x;
    int  k;
    k      = $urandom_range(0, 15);
    x.sgn  = 1'($urandom_range(0, 1));
    x.mant = 7'($urandom_range(0, 127));
    if (k == 0)      x.exp = 8'h00;
    else if (k == 1) begin x.exp = 8'hFF; x.mant = 7'h00; end
    else if (k == 2) begin x.exp = 8'hFF; x.mant = 7'($urandom_range(1, 127)); end
    else if (k < 9)  x.exp = 8'($urandom_range(100, 154));
    else             x.exp = 8'($urandom_range(1, 254));
    return x;
  endfunction

  task automatic issue(input fp_t a, input fp_t b, input fp_t res, input int lat);
    int   waited = 0;
    exp_t e;
    @(negedge clk_i);
    while (!ready_o && waited < 200) begin
      @(negedge clk_i);
      waited++;
    end
    if (!ready_o) begin
      check("issue_ready_timeout", 32'(ready_o), 32'd1);
      return;
    end
    valid_i     = 1'b1;
    op_a_i      = a;
    op_b_i      = b;
    e.res       = res;
    e.lat       = lat;
    e.drive_cyc = cyc;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    op_a_i  = fp_t'($urandom);
    op_b_i  = fp_t'($urandom);
    scb.push_back(e);
  endtask

  task automatic drain(input string name);
    int waited = 0;
    while (scb.size() != 0 && waited < 1000) begin
      @(negedge clk_i);
      waited++;
    end
    check(name, 32'(scb.size()), 32'd0);
  endtask

  // Monitor: latency on rising valid_o, result on consume, handshake exclusivity.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_v  = 0;
        exp_rdy = 0;
      end else begin
        if (exp_rdy) begin
          check("ready_after_consume", {30'd0, ready_o, valid_o}, 32'b10);
          exp_rdy = 0;
        end
        if (valid_o) check("no_ready_while_valid", 32'(ready_o), 32'd0);
        if (!valid_o && scb.size() != 0) check("no_ready_while_busy", 32'(ready_o), 32'd0);
        if (valid_o && !prev_v) begin
          if (scb.size() == 0) check("unexpected_valid", 32'(valid_o), 32'd0);
          else check("latency", 32'(cyc - scb[0].drive_cyc), 32'(scb[0].lat));
        end
        if (valid_o && ready_i) begin
          if (scb.size() == 0) begin
            check("unexpected_result", 32'(result_o), 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = scb.pop_front();
            check("result", 32'(result_o), 32'(e.res));
          end
          exp_rdy = 1;
        end
        prev_v = valid_o;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_i);
      #2;
      if (rdy_rand) ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [15:0] dir_a [11] = '{16'h40C0, 16'h3F80, 16'hBF80, 16'h0000, 16'h7FC1, 16'h0000,
                              16'h4080, 16'h0080, 16'h7F00, 16'h7F80, 16'h7F80};
  logic [15:0] dir_b [11] = '{16'h4000, 16'h4040, 16'h0000, 16'h0000, 16'h4000, 16'h40A0,
                              16'h7F80, 16'h7F00, 16'h0080, 16'h7F80, 16'hC000};
  logic [15:0] dir_r [11] = '{16'h4040, 16'h3EAA, 16'hFF80, 16'h7FC0, 16'h7FC0, 16'h0000,
                              16'h0000, 16'h0000, 16'h7F80, 16'h7FC0, 16'hFF80};
  int          dir_l [11] = '{LAT_NRM, LAT_NRM, LAT_SPC, LAT_SPC, LAT_SPC, LAT_SPC,
                              LAT_SPC, LAT_NRM, LAT_NRM, LAT_SPC, LAT_SPC};

  initial begin
    fp_t a, b;
    int  waited;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    op_a_i  = FPZero;
    op_b_i  = FPZero;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_state", {15'd0, ready_o, valid_o, 16'(result_o)}, {15'd0, 2'b10, 16'h0000});
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 11; i++) issue(fp_t'(dir_a[i]), fp_t'(dir_b[i]), fp_t'(dir_r[i]), dir_l[i]);
    drain("directed_drain");

    // Backpressure: result held, busy-time valid_i pulses ignored
    @(negedge clk_i);
    ready_i = 1'b0;
    issue(fp_t'(16'h40C0), fp_t'(16'h4000), fp_t'(16'h4040), LAT_NRM);
    waited = 0;
    while (!valid_o && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    check("bp_valid_seen", 32'(valid_o), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("bp_hold", {15'd0, valid_o, 16'(result_o)}, {15'd0, 1'b1, 16'h4040});
      valid_i = 1'b1;
      op_a_i  = fp_t'(16'h3F80);
      op_b_i  = fp_t'(16'h4040);
    end
    @(posedge clk_i);
    #2;
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check("bp_no_extra", {15'd0, ready_o, valid_o, 16'(scb.size())}, {15'd0, 2'b10, 16'd0});

    // Async reset mid-divide
    issue(fp_t'(16'h40C0), fp_t'(16'h4000), fp_t'(16'h4040), LAT_NRM);
    repeat (3) @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    scb.delete();
    #1;
    check("async_reset", {15'd0, ready_o, valid_o, 16'(result_o)}, {15'd0, 2'b10, 16'h0000});
    @(negedge clk_i);
    rst_i = 1'b0;
    issue(fp_t'(16'h40C0), fp_t'(16'h4000), fp_t'(16'h4040), LAT_NRM);
    drain("post_reset_drain");

    // Randomised operands with random downstream readiness
    rdy_rand = 1;
    for (int n = 0; n < 300; n++) begin
      a = rand_fp();
      b = rand_fp();
      issue(a, b, ref_div(a, b), is_special(a, b) ? LAT_SPC : LAT_NRM);
    end
    drain("random_drain");
    rdy_rand = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
